// File: rtl/fetch_seq.sv
// Owns the PC and fetches from imem, with a 2-entry path (output reg + skid) toward decode; imem ack in cycle N gives if_valid in N+1.
// Backpressure: a word arriving with the output reg full parks in the skid and fetching pauses until decode drains it; redirects always win.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        ex_valid,
    input  logic [1:0]  ex_pcsel,
    input  logic        ex_bne,
    input  logic        ex_zero,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_br_target,
    input  logic [25:0] ex_target,
    input  logic [31:0] ex_rs,
    output logic        flush_o
);

    // Encoding puts "request outstanding" in state[1], so imem_req comes straight off a flop.
    typedef enum logic [1:0] {
        S_START    = 2'b00,
        S_WAIT_OUT = 2'b01,
        S_FETCH    = 2'b10,
        S_DISCARD  = 2'b11
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fword_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] pend_q;
    fword_t      out_q;
    fword_t      skid_q;
    logic        out_vld;

    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        unused_pc4_bits;

    assign unused_pc4_bits = ^ex_pc4[27:0];

    always_comb begin
        redir_vld = 1'b0;
        redir_pc  = 32'h0;
        case (ex_pcsel)
            2'd1: begin
                redir_vld = ex_bne ? !ex_zero : ex_zero;
                redir_pc  = ex_br_target;
            end
            2'd2: begin
                redir_vld = 1'b1;
                redir_pc  = {ex_pc4[31:28], ex_target, 2'b00};
            end
            2'd3: begin
                redir_vld = 1'b1;
                redir_pc  = ex_rs;
            end
            default: begin
                redir_vld = 1'b0;
                redir_pc  = 32'h0;
            end
        endcase
        redir_vld     = redir_vld & ex_valid;
        redir_pc[1:0] = 2'b00;
    end

    assign flush_o   = redir_vld;
    assign imem_req  = state[1];
    assign imem_addr = addr_q;
    assign if_valid  = out_vld;
    assign if_pc     = out_q.pc;
    assign if_instr  = out_q.instr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_START;
            addr_q  <= RESET_PC;
            pend_q  <= RESET_PC;
            out_q   <= '0;
            skid_q  <= '0;
            out_vld <= 1'b0;
        end else begin
            // Decode consuming the held word empties the output reg unless refilled below.
            if (if_ready) begin
                out_vld <= 1'b0;
            end

            case (state)
                S_START: begin
                    state <= S_FETCH;
                    if (redir_vld) begin
                        addr_q <= redir_pc;
                    end
                end
                S_FETCH: begin
                    if (redir_vld) begin
                        if (imem_ack) begin
                            addr_q <= redir_pc;
                        end else begin
                            pend_q <= redir_pc;
                            state  <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        addr_q <= addr_q + 32'd4;
                        if (!out_vld || if_ready) begin
                            out_q   <= '{pc: addr_q, instr: imem_rdata};
                            out_vld <= 1'b1;
                        end else begin
                            skid_q <= '{pc: addr_q, instr: imem_rdata};
                            state  <= S_WAIT_OUT;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (redir_vld) begin
                        addr_q <= redir_pc;
                        state  <= S_FETCH;
                    end else if (if_ready) begin
                        out_q   <= skid_q;
                        out_vld <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    // The wrong-path word still has to be collected before the new address can go out.
                    if (redir_vld) begin
                        pend_q <= redir_pc;
                    end
                    if (imem_ack) begin
                        addr_q <= redir_vld ? redir_pc : pend_q;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_START;
                end
            endcase

            if (redir_vld) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the PC register and drives the instruction-memory request port for the MIPS core. It resolves next-PC redirects reported by execute using the same PCSel encoding as npc: 0 sequential, 1 branch, 2 j/jal, 3 jr/jalr. It holds fetched words in a two-entry output path (output register plus skid) toward decode, and squashes wrong-path fetches. The core has no branch delay slot.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_pc/if_instr hold a valid instruction
- if_pc  out  32  address of if_instr
- if_instr  out  32  instruction to decode
- if_ready  in  1  decode accepts the held word this cycle
- ex_valid  in  1  execute holds a resolved control instruction
- ex_pcsel  in  2  0 none, 1 branch, 2 j/jal, 3 jr/jalr
- ex_bne  in  1  branch is bne (taken on !ex_zero); otherwise beq (taken on ex_zero)
- ex_zero  in  1  ALU zero flag
- ex_pc4  in  32  PC+4 of the execute instruction
- ex_br_target  in  32  computed branch target
- ex_target  in  26  j/jal instr_index
- ex_rs  in  32  register target for jr/jalr
- flush_o  out  1  redirect taken this cycle; decode and younger stages squash

## Operation
- Taken condition: taken = ex_valid & (sel==2 | sel==3 | (sel==1 & (ex_bne ? !ex_zero : ex_zero))), where sel is ex_pcsel.
- Target by sel:
  - 1: ex_br_target
  - 2: {ex_pc4[31:28], ex_target, 2'b00}
  - 3: ex_rs
  - Bits [1:0] of every target are forced to 0.
- flush_o = taken. It is combinational, in the same cycle as the ex_* inputs.
- Registers:
  - addr_q: the outstanding or next fetch address.
  - pend_q: redirect target held while discarding.
  - out (if_* outputs) and skid (pc + instr).
- States, all transitions on the rising clk edge:
  - START: imem_req=0. Next state is FETCH, or FETCH at the target if taken.
  - FETCH: imem_req=1, imem_addr=addr_q.
    - On ack with no taken: addr_q<=addr_q+4.
      - If the output register is free (!if_valid | if_ready): out<=data, if_valid<=1.
      - Otherwise: skid<=data, go WAIT_OUT.
    - On taken with ack in the same cycle: drop data, addr_q<=target, stay FETCH.
    - On taken without ack: pend_q<=target, go DISCARD.
  - WAIT_OUT: imem_req=0. On if_ready: out<=skid, go FETCH. On taken: drop skid, addr_q<=target, go FETCH.
  - DISCARD: imem_req=1, imem_addr=addr_q (old address, unchanged).
    - A further taken overwrites pend_q.
    - On ack: data dropped, addr_q<=pend_q, or the new target if taken in the same cycle; go FETCH.
- Taken in any state:
  - if_valid<=0 and the skid is invalidated on the next edge.
  - A word handed to decode in the same cycle (if_ready=1) is squashed by decode via flush_o.
- Redirect priority: taken beats sequential, ack and if_ready in all states.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, flush_o=0 (while ex_valid=0), state=START, addr_q=RESET_PC.
- First imem_req: the cycle after rstn deasserts.
- Latency: ack in cycle N gives if_valid=1 in cycle N+1.
- Throughput: with zero-wait memory and if_ready=1, one instruction per cycle.
- Redirect penalty: taken in cycle N gives imem_addr=target in cycle N+1 if no fetch is outstanding. Otherwise it takes one cycle after the old ack.
- Handshake: imem_req/imem_addr never change while imem_req=1 without imem_ack.
- if_pc/if_instr are stable while if_valid=1 and if_ready=0.
- rstn assertion mid-operation immediately forces all reset values, including during DISCARD. Any outstanding memory transaction is abandoned.

## Test plan
- Reset release, memory always acks, if_ready=1:
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - if_pc follows one cycle later, one word per cycle.
- Backpressure: if_ready=0 for 3 cycles after 2 fetches, then imem_req drops (WAIT_OUT) and if_pc holds 0x3000. After release, 0x3000 then 0x3004 are delivered in order with no loss and no duplication.
- beq at ex_pc4=0x3010, zero=1, ex_br_target=0x3040:
  - flush_o=1, next imem_addr=0x3040.
  - Same inputs with ex_bne=1 give no flush and a sequential fetch.
- jr with ex_rs=0x1233 while a fetch of 0x3008 is outstanding (ack delayed 2 cycles):
  - imem_addr stays 0x3008 until ack.
  - That data is never delivered; next imem_addr is 0x1230.
- j with ex_pc4=0x9000_0004, ex_target=26'h0000100 gives target 0x9000_0400. Fetching from 0xFFFF_FFFC next requests 0x0000_0000.
- Assert rstn in DISCARD: outputs return to reset values at once. The first request after release is RESET_PC.
